// File: rtl/fetch_decode_unit_pkg.sv
// Processor-wide definitions shared by the fetch stage: field positions, state
// encodings and PC arithmetic constants.
package fetch_decode_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] PC_STEP_DEFAULT = 16'd2;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 9;
    localparam int RB_HI   = 8;
    localparam int RB_LO   = 6;
    localparam int IMM6_HI = 5;
    localparam int IMM6_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Memory-request and decode-stage signals of the fetch unit, plus its state for
// observation. Handshakes: a transfer happens on a rising edge where the source
// holds its request/valid high and the sink holds its ready high.
interface fetch_decode_unit_if;
    import fetch_decode_unit_pkg::*;

    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [PC_W-1:0]    dec_pc;
    logic [3:0]         dec_op;
    logic [2:0]         dec_ra;
    logic [2:0]         dec_rb;
    logic [5:0]         dec_imm6;
    fetch_state_e       dbg_state;

    modport master (
        output mem_req, mem_addr, dec_valid, dec_pc, dec_op, dec_ra, dec_rb,
               dec_imm6, dbg_state,
        input  mem_rdata, mem_ready, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  mem_req, mem_addr, dec_valid, dec_pc, dec_op, dec_ra, dec_rb,
               dec_imm6, dbg_state,
        output mem_rdata, mem_ready, redirect, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_decode_unit_instruction_register.sv
// Load-enabled instruction register; the decoded fields are plain slices of it
// so they add no latency.
module instruction_register
    import fetch_decode_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] d_i,
    output logic [3:0]         op_o,
    output logic [2:0]         ra_o,
    output logic [2:0]         rb_o,
    output logic [5:0]         imm6_o
);

    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;

    always_comb begin
        ir_d = ir_q;
        if (load_i) begin
            ir_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign op_o   = ir_q[OP_HI:OP_LO];
    assign ra_o   = ir_q[RA_HI:RA_LO];
    assign rb_o   = ir_q[RB_HI:RB_LO];
    assign imm6_o = ir_q[IMM6_HI:IMM6_LO];

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch stage: PC, instruction-memory request FSM and hand-off of the latched
// instruction to decode.
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEFAULT
)(
    input  logic                  clk,
    input  logic                  reset,
    fetch_decode_unit_if.master   bus
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] dec_pc_q, dec_pc_d;
    logic            ir_load;

    // Redirect overrides everything but reset: a word returning in the same
    // cycle is dropped and a held instruction is squashed.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dec_pc_d = dec_pc_q;
        ir_load  = 1'b0;
        if (bus.redirect) begin
            state_d = S_REQ;
            pc_d    = bus.redirect_pc;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (bus.mem_ready) begin
                        ir_load  = 1'b1;
                        dec_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.dec_ready) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            dec_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dec_pc_q <= dec_pc_d;
        end
    end

    instruction_register u_ir (
        .clk    (clk),
        .reset  (reset),
        .load_i (ir_load),
        .d_i    (bus.mem_rdata),
        .op_o   (bus.dec_op),
        .ra_o   (bus.dec_ra),
        .rb_o   (bus.dec_rb),
        .imm6_o (bus.dec_imm6)
    );

    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.dec_valid = (state_q == S_HOLD);
    assign bus.mem_addr  = pc_q;
    assign bus.dec_pc    = dec_pc_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for the fetch stage: directed walk through reset, fetch, backpressure,
// redirect and wrap, then random traffic against a transaction-level model.
module tb_fetch_decode_unit;
    import fetch_decode_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_decode_unit_if bus ();

    fetch_decode_unit #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected decode fields are sliced straight out of the instruction word.
    task automatic check_fields(input string tag, input logic [15:0] pc, input logic [15:0] w);
        chk({tag, "_pc"},   32'(bus.dec_pc),   32'(pc));
        chk({tag, "_op"},   32'(bus.dec_op),   32'(w[15:12]));
        chk({tag, "_ra"},   32'(bus.dec_ra),   32'(w[11:9]));
        chk({tag, "_rb"},   32'(bus.dec_rb),   32'(w[8:6]));
        chk({tag, "_imm6"}, 32'(bus.dec_imm6), 32'(w[5:0]));
    endtask

    logic [31:0] exp_q[$];
    logic [15:0] exp_addr;
    logic [15:0] sext;
    logic [31:0] head;
    logic        expect_valid_now;
    logic        expect_req_now;
    logic        obs_req;
    logic        obs_valid;
    int          delivered;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready   = 1'b0;

        // 1: reset for 3 cycles, one idle cycle, then a request at 0x0000
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req", 32'(bus.mem_req), 32'd0);
            chk("rst_valid", 32'(bus.dec_valid), 32'd0);
        end
        chk("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        chk("rst_pc", 32'(bus.dec_pc), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'h0000);
        chk("rst_op", 32'(bus.dec_op), 32'd0);
        reset = 1'b0;
        chk("idle_req", 32'(bus.mem_req), 32'd0);
        step();
        chk("first_req", 32'(bus.mem_req), 32'd1);
        chk("first_addr", 32'(bus.mem_addr), 32'h0000);

        // 2: return 0x3A21
        bus.mem_rdata = 16'h3A21;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("w1_valid", 32'(bus.dec_valid), 32'd1);
        check_fields("w1", 16'h0000, 16'h3A21);
        sext = {{10{bus.dec_imm6[5]}}, bus.dec_imm6};
        chk("w1_sext", 32'(sext), 32'h0000FFE1);

        // 3: backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_req", 32'(bus.mem_req), 32'd0);
            chk("bp_valid", 32'(bus.dec_valid), 32'd1);
            check_fields("bp", 16'h0000, 16'h3A21);
        end
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        chk("acc_req", 32'(bus.mem_req), 32'd1);
        chk("acc_addr", 32'(bus.mem_addr), 32'h0002);
        chk("acc_valid", 32'(bus.dec_valid), 32'd0);
        step();
        chk("acc_req_hold", 32'(bus.mem_req), 32'd1);
        chk("acc_addr_hold", 32'(bus.mem_addr), 32'h0002);

        // 4: redirect coinciding with a returning word
        bus.mem_rdata   = 16'hFFFF;
        bus.mem_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        step();
        bus.mem_ready = 1'b0;
        bus.redirect  = 1'b0;
        chk("rd_valid", 32'(bus.dec_valid), 32'd0);
        chk("rd_req", 32'(bus.mem_req), 32'd1);
        chk("rd_addr", 32'(bus.mem_addr), 32'h0100);
        check_fields("rd_keep", 16'h0000, 16'h3A21);

        // 5: redirect to 0xFFFE and wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        step();
        bus.redirect = 1'b0;
        chk("wr_addr", 32'(bus.mem_addr), 32'hFFFE);
        bus.mem_rdata = 16'h1234;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("wr_valid", 32'(bus.dec_valid), 32'd1);
        check_fields("wr", 16'hFFFE, 16'h1234);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        chk("wr_next_req", 32'(bus.mem_req), 32'd1);
        chk("wr_next_addr", 32'(bus.mem_addr), 32'h0000);

        // 6: reset while holding with dec_ready high
        bus.mem_rdata = 16'h5555;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("h6_valid", 32'(bus.dec_valid), 32'd1);
        bus.dec_ready = 1'b1;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        bus.mem_ready = 1'b0;
        chk("r6_valid", 32'(bus.dec_valid), 32'd0);
        chk("r6_state", 32'(bus.dbg_state), 32'(S_IDLE));
        chk("r6_pc", 32'(bus.dec_pc), 32'd0);
        chk("r6_op", 32'(bus.dec_op), 32'd0);
        reset = 1'b0;
        chk("r6_idle_req", 32'(bus.mem_req), 32'd0);
        step();
        chk("r6_req", 32'(bus.mem_req), 32'd1);
        chk("r6_addr", 32'(bus.mem_addr), 32'h0000);

        // Redirect during the idle cycle replaces RESET_PC
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        step();
        bus.redirect = 1'b0;
        chk("idle_rd_req", 32'(bus.mem_req), 32'd1);
        chk("idle_rd_addr", 32'(bus.mem_addr), 32'h0200);

        // Random traffic checked against an address/instruction model
        exp_addr = 16'h0200;
        exp_q.delete();
        expect_valid_now = 1'b0;
        expect_req_now   = 1'b1;
        delivered        = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            obs_req   = bus.mem_req;
            obs_valid = bus.dec_valid;
            chk("rnd_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("rnd_excl", 32'(obs_req & obs_valid), 32'd0);
            if (expect_valid_now) chk("rnd_lat", 32'(obs_valid), 32'd1);
            if (expect_req_now) chk("rnd_req", 32'(obs_req), 32'd1);
            if (obs_valid) begin
                chk("rnd_qsize", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    head = exp_q[0];
                    check_fields("rnd", head[31:16], head[15:0]);
                end
            end

            bus.mem_ready   = ($urandom_range(0, 2) == 0);
            bus.mem_rdata   = 16'($urandom);
            bus.dec_ready   = ($urandom_range(0, 1) == 0);
            bus.redirect    = ($urandom_range(0, 11) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);

            expect_valid_now = 1'b0;
            expect_req_now   = 1'b0;
            if (bus.redirect) begin
                exp_addr = bus.redirect_pc;
                if (obs_valid && exp_q.size() > 0) void'(exp_q.pop_front());
                expect_req_now = 1'b1;
            end else begin
                if (obs_req && bus.mem_ready) begin
                    exp_q.push_back({exp_addr, bus.mem_rdata});
                    exp_addr = exp_addr + 16'd2;
                    expect_valid_now = 1'b1;
                end
                if (obs_valid && bus.dec_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    expect_req_now = 1'b1;
                    delivered++;
                end
            end
            step();
        end
        bus.mem_ready = 1'b0;
        bus.redirect  = 1'b0;
        bus.dec_ready = 1'b0;
        chk("rnd_progress", 32'(delivered > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
